rr_outport_arbiter: RTL and testbench
=====================================

// Module: rr_outport_arbiter
// PURPOSE
//  Per-output-port wormhole arbiter for the 5-port router (local, N, E, S, W).
//  Shares one crossbar output among up to NPORTS input buffers with round-robin fairness.
//  Holds each grant from head flit to tail flit.
//  Drives the one-hot crossbar select (bit i = input i, same encoding as the select
//  vectors) and the dequeue strobes back to the input buffers.
// PARAMETERS
//  NPORTS  5  number of requesting input ports
//  PTR_W   3  width of round-robin pointer; must satisfy 2**PTR_W >= NPORTS
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       synchronous reset, active-high
//  req        in   NPORTS  input i has a head flit routed to this output
//  flit_valid in   NPORTS  input i has a flit available at its buffer head
//  flit_tail  in   NPORTS  flit at head of input i is a tail flit (single-flit pkt: head=tail)
//  out_ready  in   1       downstream can accept one flit this cycle (credit available)
//  grant      out  NPORTS  registered one-hot crossbar select; all-zero when idle
//  busy       out  1       registered; 1 while a packet holds this output
//  fwd        out  1       comb.: a flit crosses this cycle = busy & flit_valid[g] & out_ready
//  pop        out  NPORTS  comb.: dequeue strobe = grant & {NPORTS{fwd}}
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, grant=0, busy=0, ptr=0 (input 0 highest priority).
//    fwd=0 and pop=0 follow combinationally.
//  - Reset overrides everything, including mid-packet.
//  - FSM state IDLE:
//      - fwd=0, pop=0.
//      - If |req: pick the first i with req[i]=1 in circular order ptr, ptr+1, ...,
//        NPORTS-1, 0, ...
//      - Next edge: grant=onehot(i), busy=1, state=LOCK.
//      - Arbitration latency is 1 cycle from req to grant.
//      - If req=0: stay IDLE.
//  - FSM state LOCK (granted index g):
//      - grant is constant. req changes (including req[g] dropping) are ignored.
//      - fwd=flit_valid[g] & out_ready.
//      - flit_valid/flit_tail of non-granted inputs are ignored.
//      - fwd & flit_tail[g] at an edge: next grant=0, busy=0, state=IDLE,
//        ptr=(g==NPORTS-1)?0:g+1.
//      - Otherwise hold. There is no timeout.
//  - Throughput: exactly one IDLE (bubble) cycle between a tail transfer and the next grant.
//    No same-cycle re-arbitration.
//  - Invariants:
//      - grant is zero or one-hot, and is never X.
//      - grant is only ever given to an input whose req was 1 in the arbitration cycle.
//      - pop is a subset of grant.
//      - At most one pop per cycle.
//  - Fairness: a continuously requesting input waits at most NPORTS-1 other packets.
//  - out_ready=0 or flit_valid[g]=0: no transfer, no pop, no state change.
//  - ptr advances only on packet completion, never on arbitration alone.
// TESTING
//  1. rst 2 cycles then req=0 for 10 cycles -> grant=00000, busy=0, pop=0 throughout.
//  2. From reset, req=10110 held, 3-flit pkts, out_ready=1:
//     - grant=00010 one cycle after req.
//     - pop=00010 on 3 consecutive cycles, then 1 idle cycle.
//     - Grant sequence: 00100, 10000, 00010.
//  3. Mid-packet on input 2, out_ready=0 for 4 cycles -> fwd=0, pop=0, grant=00100 stable.
//     Transfer resumes on the first cycle with out_ready=1.
//  4. req=11111, all single-flit pkts, out_ready=1:
//     - grants 00001,00010,00100,01000,10000,00001, each followed by one cycle with grant=0.
//  5. rst asserted while grant=01000 mid-packet -> next edge grant=0, busy=0.
//     Then req=01001 -> grant=00001 (ptr reset to 0).
//  6. In LOCK on input 0, req[0] drops after the head flit -> grant held until the tail pops.
//     Simultaneous req[1]=1 is granted only after the bubble cycle.

Source files
------------

// File: rtl/rr_outport_arbiter.sv
// Wormhole output-port arbiter: round-robin choice among requesting inputs,
// grant held from head flit until the tail flit is forwarded.
module rr_outport_arbiter #(
    parameter int NPORTS = 5,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] flit_valid,
    input  logic [NPORTS-1:0] flit_tail,
    input  logic              out_ready,
    output logic [NPORTS-1:0] grant,
    output logic              busy,
    output logic              fwd,
    output logic [NPORTS-1:0] pop
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_reg, state_next;
    logic [NPORTS-1:0] grant_reg, grant_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [PTR_W-1:0]  owner_reg, owner_next;

    logic [NPORTS-1:0] hi_req;
    logic [NPORTS-1:0] pick_src;
    logic [NPORTS-1:0] pick_onehot;
    logic [PTR_W-1:0]  pick_idx;
    logic              tail_done;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_hi_req
            assign hi_req[gi] = req[gi] && (PTR_W'(gi) >= ptr_reg);
        end
    endgenerate

    assign pick_src    = (|hi_req) ? hi_req : req;
    assign pick_onehot = pick_src & (~pick_src + NPORTS'(1));

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    assign tail_done = fwd && flit_tail[owner_reg];

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = LOCK;
                    grant_next = pick_onehot;
                    owner_next = pick_idx;
                end
            end
            LOCK: begin
                // Pointer moves only when a packet completes, giving the next input priority.
                if (tail_done) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = (owner_reg == PTR_W'(NPORTS - 1)) ? '0 : owner_reg + PTR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_comb begin
        fwd   = (state_reg == LOCK) && flit_valid[owner_reg] && out_ready;
        pop   = grant_reg & {NPORTS{fwd}};
        grant = grant_reg;
        busy  = (state_reg == LOCK);
    end

endmodule

// File: tb/tb_rr_outport_arbiter.sv
// Bench for rr_outport_arbiter: directed scenarios then random traffic, all
// checked against a packet-level round-robin model.
module tb_rr_outport_arbiter;

    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req, flit_valid, flit_tail, grant, pop;
    logic          out_ready, busy, fwd;

    int n_vec = 0;
    int n_err = 0;

    int  m_owner = -1;
    int  m_ptr   = 0;
    bit  m_known = 1'b0;
    int  pkt_left [NP];
    int  len_cfg = 3;
    logic [NP-1:0] prev_grant = '0;
    logic [NP-1:0] glog [$];

    rr_outport_arbiter #(.NPORTS(NP), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_valid(flit_valid),
        .flit_tail(flit_tail), .out_ready(out_ready), .grant(grant),
        .busy(busy), .fwd(fwd), .pop(pop)
    );

    always #5 clk = ~clk;

    function automatic int new_len();
        return (len_cfg > 0) ? len_cfg : int'($urandom_range(1, 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reload_pkts();
        for (int i = 0; i < NP; i++) pkt_left[i] = new_len();
    endtask

    task automatic cycle(input logic c_rst, input logic [NP-1:0] c_req,
                         input logic [NP-1:0] c_valid, input logic c_rdy);
        logic [NP-1:0] eg, ep;
        logic          ef;
        int            idx;
        bit            found;
        rst        = c_rst;
        req        = c_req;
        flit_valid = c_valid;
        out_ready  = c_rdy;
        for (int i = 0; i < NP; i++) flit_tail[i] = (pkt_left[i] == 1);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        ef = (m_owner >= 0) && c_valid[m_owner] && c_rdy;
        ep = ef ? eg : '0;
        if (m_known) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("fwd", 32'(fwd), 32'(ef));
            chk("pop", 32'(pop), 32'(ep));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (grant !== '0 && prev_grant === '0) glog.push_back(grant);
        end
        prev_grant = grant;
        @(posedge clk);
        if (c_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_known = 1'b1;
            reload_pkts();
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NP; k++) begin
                idx = (m_ptr + k) % NP;
                if (!found && c_req[idx]) begin
                    m_owner = idx;
                    found   = 1'b1;
                end
            end
        end else if (ef) begin
            idx = m_owner;
            if (pkt_left[idx] == 1) begin
                m_ptr   = (idx + 1) % NP;
                m_owner = -1;
            end
            pkt_left[idx]--;
            if (pkt_left[idx] == 0) pkt_left[idx] = new_len();
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, '0, 1'b0);
    endtask

    initial begin
        logic [NP-1:0] exp2 [4];
        logic [NP-1:0] exp4 [6];
        exp2 = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
        exp4 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        for (int i = 0; i < NP; i++) pkt_left[i] = 3;
        rst = 1'b1; req = '0; flit_valid = '0; flit_tail = '0; out_ready = 1'b0;

        // 1: idle after reset
        do_reset(2);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b1);

        // 2: three-flit packets, rotation across 10110
        len_cfg = 3;
        do_reset(1);
        glog.delete();
        for (int i = 0; i < 16; i++) cycle(1'b0, 5'b10110, 5'b11111, 1'b1);
        chk("t2_ngrants", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) chk($sformatf("t2_grant%0d", i), 32'(glog[i]), 32'(exp2[i]));

        // 3: back-pressure in mid-packet
        do_reset(1);
        cycle(1'b0, 5'b00100, 5'b11111, 1'b1);
        cycle(1'b0, 5'b00100, 5'b11111, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'b00100, 5'b11111, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'b00000, 5'b11111, 1'b1);

        // 4: all inputs, single-flit packets
        len_cfg = 1;
        do_reset(1);
        glog.delete();
        for (int i = 0; i < 12; i++) cycle(1'b0, 5'b11111, 5'b11111, 1'b1);
        chk("t4_ngrants", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < glog.size()) chk($sformatf("t4_grant%0d", i), 32'(glog[i]), 32'(exp4[i]));

        // 5: reset in mid-packet restores pointer to 0
        len_cfg = 3;
        do_reset(1);
        cycle(1'b0, 5'b01000, 5'b11111, 1'b1);
        cycle(1'b0, 5'b01000, 5'b11111, 1'b1);
        do_reset(1);
        glog.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'b01001, 5'b11111, 1'b0);
        chk("t5_ngrants", 32'(glog.size()), 32'd1);
        if (glog.size() > 0) chk("t5_grant", 32'(glog[0]), 32'd1);

        // 6: request drops during lock, next requester waits for bubble
        do_reset(1);
        glog.delete();
        cycle(1'b0, 5'b00001, 5'b11111, 1'b1);
        cycle(1'b0, 5'b00001, 5'b11111, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 5'b00010, 5'b11111, 1'b1);
        chk("t6_ngrants", 32'(glog.size()), 32'd2);
        if (glog.size() > 1) chk("t6_grant1", 32'(glog[1]), 32'd2);

        // random traffic with occasional reset
        len_cfg = 0;
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 63) == 0, NP'($urandom), NP'($urandom | $urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
